fetch_stream: RTL and testbench
===============================

Name: fetch_stream

Overview:
- Parametrised, pipelined successor to the single-cycle Y86-64 fetch stage.
- Issues wide reads to a synchronous instruction memory and buffers the returned bytes in a circular byte queue.
- Decodes variable-length instructions (1/2/9/10 bytes) from the queue head and presents them to decode over a valid/ready handshake.
- Supports PC redirect with flush, plus halt, invalid-instruction and memory-error stop states.

Parameters:
- MEM_BYTES, 2048: instruction memory size; valid byte addresses are 0..MEM_BYTES-1.
- FETCH_BYTES, 4: bytes returned per memory read; power of two, 1..16.
- QUEUE_BYTES, 16: byte queue depth; power of two, at least 10 and at least 2*FETCH_BYTES.
- RESET_PC, 0: PC loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  64  new PC.
- imem_req  out  1  read request this cycle.
- imem_addr  out  64  read address, byte-granular (unaligned allowed).
- imem_rdata  in  8*FETCH_BYTES  data for the request of the previous cycle; byte k (bits 8k+7:8k) is address imem_addr+k.
- out_valid  out  1  instruction presented.
- out_ready  in  1  decode accepts.
- pc  out  64  address of the presented instruction.
- icode  out  4  opcode.
- ifun  out  4  function code.
- rA  out  4  register specifier A.
- rB  out  4  register specifier B.
- valC  out  64  constant.
- valP  out  64  next sequential PC.
- inst_valid  out  1  0 = invalid icode.
- imem_er  out  1  instruction touches an address >= MEM_BYTES.
- hlt_er  out  1  halt instruction.

Behaviour:
- Reset (async, rst_n=0):
  - queue count=0, in-flight=0, fetch_pc=dec_pc=RESET_PC, state=RUN.
  - imem_req=0, out_valid=0; all field outputs 0; rA=rB=4'hF.
- Memory timing: fixed 1-cycle read latency. A request in cycle n returns data in cycle n+1, which is written into the queue at the end of cycle n+1.
- Request rule: in state RUN, with no redirect and fetch_pc < MEM_BYTES, issue a request when count + FETCH_BYTES*(in-flight) + FETCH_BYTES <= QUEUE_BYTES.
  - imem_addr = fetch_pc.
  - fetch_pc += FETCH_BYTES.
  - Back-to-back requests are allowed.
- Out-of-range bytes: returned bytes whose address is >= MEM_BYTES are written to the queue as 8'h00.
- Length from the head byte's upper nibble:
  - 0, 1, 9 -> 1 byte.
  - 2, 6, A, B -> 2 bytes.
  - 7, 8 -> 9 bytes.
  - 3, 4, 5 -> 10 bytes.
  - others -> 1 byte, with inst_valid=0.
- Field extraction (b0..b9 are queue bytes starting at the head):
  - icode = b0[7:4], ifun = b0[3:0].
  - rA = b1[7:4], rB = b1[3:0] for lengths 2 and 10; otherwise rA = rB = F.
  - valC = {b2..b9} (b2 most significant) for 3/4/5; {b1..b8} for 7/8; 0 otherwise.
  - pc = dec_pc; valP = dec_pc + len, 64-bit wrap.
- out_valid conditions:
  - State RUN, no redirect, and count >= len; or
  - the memory-error condition below.
- Memory error:
  - If dec_pc >= MEM_BYTES: out_valid=1, imem_er=1, icode=ifun=0, rA=rB=F, valC=0, valP=dec_pc.
  - If dec_pc + len > MEM_BYTES: once len bytes are present, imem_er=1 and fields are decoded normally.
- Status flags: hlt_er=1 when icode==0 and imem_er==0.
- Handshake and transfer:
  - A transfer occurs when out_valid && out_ready.
  - On transfer, len bytes are popped and dec_pc = valP.
  - While out_valid && !out_ready, all outputs hold stable.
- State STOP:
  - Entered on transfer of an instruction with hlt_er, imem_er or !inst_valid.
  - In STOP: no requests, out_valid=0, any returning data is discarded.
  - Exited only via redirect.
- Redirect (highest priority):
  - Effects at the clock edge: count=0, in-flight data dropped, fetch_pc = dec_pc = redirect_pc, state = RUN.
  - out_valid=0 in the redirect cycle.
  - A transfer coinciding with redirect is still counted as consumed by decode, but no internal pop is applied.
- Queue: circular, pointers wrap modulo QUEUE_BYTES. Push and pop in the same cycle are both applied. count never exceeds QUEUE_BYTES and never goes negative.
- First-instruction latency: with FETCH_BYTES=4, reset released at edge 0, request at cycle 1, data at cycle 2, out_valid for a 1- or 2-byte instruction at cycle 3.

Test Plan:
- Straight-line program, memory holds 30 F0 00 00 00 00 00 00 00 04 then 60 03, out_ready=1 -> first output: icode=3, rA=F, rB=0, valC=4, pc=0, valP=10. Second output: icode=6, rA=0, rB=3, valP=12.
- Backpressure: out_ready=0 for 20 cycles -> outputs stable; imem_req drops once count reaches QUEUE_BYTES (16); count never exceeds 16. Releasing out_ready resumes in order with no lost or duplicated bytes.
- Redirect while a request is in flight, redirect_pc=0x30 -> next output has pc=0x30; the stale returned beat is not enqueued.
- Halt: byte 00 at 0x14 -> output hlt_er=1, valP=0x15. After the transfer, out_valid=0 and imem_req=0 until a redirect, which restarts fetch.
- Memory edge: call (0x80) at MEM_BYTES-4 -> imem_er=1, icode=8, then STOP. Redirect to MEM_BYTES -> imem_er=1, icode=0, valP=MEM_BYTES.
- Invalid icode byte C0 -> inst_valid=0, valP=pc+1, then STOP. Asserting rst_n=0 mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_stream.sv
// Pipelined Y86-64 fetch: wide reads into a circular byte queue and variable-length decode at the head.
// Fields are decoded combinationally from the queue head; requests and addresses are registered.
module fetch_stream #(
  parameter int unsigned MEM_BYTES   = 2048,
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned QUEUE_BYTES = 16,
  parameter logic [63:0] RESET_PC    = 64'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  output logic                     imem_req,
  output logic [63:0]              imem_addr,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              pc,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               rA,
  output logic [3:0]               rB,
  output logic [63:0]              valC,
  output logic [63:0]              valP,
  output logic                     inst_valid,
  output logic                     imem_er,
  output logic                     hlt_er
);

  localparam int QW = $clog2(QUEUE_BYTES);
  localparam int CW = QW + 1;
  localparam logic [63:0]   MEM_END = 64'(MEM_BYTES);
  localparam logic [CW-1:0] FB_C    = CW'(FETCH_BYTES);
  localparam logic [CW+1:0] FB_W    = (CW+2)'(FETCH_BYTES);
  localparam logic [CW+1:0] QB_W    = (CW+2)'(QUEUE_BYTES);

  typedef enum logic {S_RUN, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, pop_n;
  logic          beat_q, beat_d, rvld_q, rvld_d, req_q, req_d;
  logic [63:0]   addr_q, addr_d, rd_addr_q;
  logic [63:0]   fetch_pc_q, fetch_pc_d, dec_pc_q, dec_pc_d, fetch_base;
  logic [CW+1:0] need;
  logic [7:0]    qmem_q [QUEUE_BYTES];

  logic [7:0] b [10];
  logic [3:0] len;
  logic       legal, pc_oob, run_ok, xfer, push;

  always_comb begin
    for (int i = 0; i < 10; i++) b[i] = qmem_q[head_q + QW'(i)];
  end

  always_comb begin
    len   = 4'd1;
    legal = 1'b1;
    case (b[0][7:4])
      4'h0, 4'h1, 4'h9:       len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                legal = 1'b0;
    endcase
  end

  assign pc_oob    = dec_pc_q >= MEM_END;
  assign run_ok    = (state_q == S_RUN) && !redirect;
  assign out_valid = run_ok && (pc_oob || (count_q >= CW'(len)));
  assign xfer      = out_valid && out_ready;
  assign push      = rvld_q && run_ok;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  always_comb begin
    pc = '0; icode = '0; ifun = '0; rA = 4'hF; rB = 4'hF;
    valC = '0; valP = '0; inst_valid = 1'b0; imem_er = 1'b0; hlt_er = 1'b0;
    if (out_valid) begin
      pc = dec_pc_q;
      if (pc_oob) begin
        valP       = dec_pc_q;
        imem_er    = 1'b1;
        inst_valid = 1'b1;
      end else begin
        icode      = b[0][7:4];
        ifun       = b[0][3:0];
        inst_valid = legal;
        valP       = dec_pc_q + 64'(len);
        imem_er    = (MEM_END - dec_pc_q) < 64'(len);
        if (len == 4'd2 || len == 4'd10) begin
          rA = b[1][7:4];
          rB = b[1][3:0];
        end
        if (len == 4'd10)     valC = {b[2], b[3], b[4], b[5], b[6], b[7], b[8], b[9]};
        else if (len == 4'd9) valC = {b[1], b[2], b[3], b[4], b[5], b[6], b[7], b[8]};
      end
      hlt_er = (icode == 4'h0) && !imem_er;
    end
  end

  // Past the end of memory, beats are generated internally (no imem_req) and land as zeros,
  // so an instruction straddling MEM_BYTES still completes and reports imem_er.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    dec_pc_d   = dec_pc_q;
    addr_d     = addr_q;
    beat_d     = 1'b0;
    req_d      = 1'b0;
    rvld_d     = beat_q && !redirect;
    fetch_base = redirect ? redirect_pc : fetch_pc_q;
    pop_n      = (xfer && !pc_oob) ? CW'(len) : '0;
    if (redirect) begin
      state_d  = S_RUN;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      dec_pc_d = redirect_pc;
    end else begin
      if (push) tail_d = tail_q + QW'(FETCH_BYTES);
      count_d = count_q + (push ? FB_C : '0) - pop_n;
      head_d  = head_q + QW'(pop_n);
      if (xfer) begin
        dec_pc_d = valP;
        if (hlt_er || imem_er || !inst_valid) state_d = S_STOP;
      end
    end
    need       = {2'b00, count_d} + (rvld_d ? FB_W : '0) + FB_W;
    fetch_pc_d = fetch_base;
    if (state_d == S_RUN && need <= QB_W) begin
      beat_d     = 1'b1;
      req_d      = fetch_base < MEM_END;
      addr_d     = fetch_base;
      fetch_pc_d = fetch_base + 64'(FETCH_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_q     <= 1'b0;
      rvld_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      fetch_pc_q <= RESET_PC;
      dec_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      rvld_q     <= rvld_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      rd_addr_q  <= addr_q;
      fetch_pc_q <= fetch_pc_d;
      dec_pc_q   <= dec_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < FETCH_BYTES; k++)
        qmem_q[tail_q + QW'(k)] <= (rd_addr_q + 64'(k) >= MEM_END) ? 8'h00 : imem_rdata[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_fetch_stream.sv
// Bench for fetch_stream: decode vector table plus scoreboarded instruction streams.
module tb_fetch_stream;
  localparam int MEM = 2048;
  localparam int FB  = 4;
  localparam int QB  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect = 1'b0;
  logic [63:0]   redirect_pc = '0;
  logic          imem_req;
  logic [63:0]   imem_addr;
  logic [8*FB-1:0] imem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   pc, valC, valP;
  logic [3:0]    icode, ifun, rA, rB;
  logic          inst_valid, imem_er, hlt_er;

  fetch_stream #(.MEM_BYTES(MEM), .FETCH_BYTES(FB), .QUEUE_BYTES(QB), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .pc(pc), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .inst_valid(inst_valid),
    .imem_er(imem_er), .hlt_er(hlt_er)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        iv, ie, he;
  } exp_t;

  typedef struct {
    logic [63:0] pc;
    logic [79:0] bytes;
    int          nb;
    exp_t        e;
  } vec_t;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb [$];
  logic [7:0] mem [MEM];
  vec_t tbl [11];

  function automatic exp_t mk(input logic [63:0] p, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                              input logic [63:0] vp, input logic iv, input logic ie, input logic he);
    exp_t e;
    e.pc = p; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
    e.valc = vc; e.valp = vp; e.iv = iv; e.ie = ie; e.he = he;
    return e;
  endfunction

  function automatic exp_t cur();
    exp_t e;
    e.pc = pc; e.icode = icode; e.ifun = ifun; e.ra = rA; e.rb = rB;
    e.valc = valC; e.valp = valP; e.iv = inst_valid; e.ie = imem_er; e.he = hlt_er;
    return e;
  endfunction

  function automatic logic [7:0] rd(input logic [63:0] a);
    return (a < 64'(MEM)) ? mem[a[10:0]] : 8'hAA;
  endfunction

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    if (a < 64'(MEM)) mem[a[10:0]] = d;
  endtask

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  // Synchronous instruction memory, one-cycle latency.
  always @(posedge clk) begin
    if (imem_req)
      for (int k = 0; k < FB; k++) imem_rdata[8*k +: 8] <= rd(imem_addr + 64'(k));
  end

  // Scoreboard: every transfer must match the oldest expected instruction.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("xfer_unexpected", cur(), '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("xfer_pc%0h", e.pc), cur(), e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [63:0] a);
    redirect = 1'b1;
    redirect_pc = a;
    step();
    redirect = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk(nm, sb.size(), 0);
  endtask

  task automatic check_stop(input string nm, input int n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (out_valid || imem_req) bad = 1'b1;
      step();
    end
    chk(nm, bad, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t rst_e, snap;
    int   cyc, nreq;
    logic have, bad, v1, v2, v3;

    rst_e = mk(64'h0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[0]  = '{64'h40, {8'hC0, 72'h0}, 1,
                mk(64'h40, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{64'h50, 80'h30F3_0102030405060708, 10,
                mk(64'h50, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h5A, 1'b1, 1'b0, 1'b0)};
    tbl[2]  = '{64'h60, {72'h70_0000000000000100, 8'h0}, 9,
                mk(64'h60, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h69, 1'b1, 1'b0, 1'b0)};
    tbl[3]  = '{64'h70, {8'h90, 72'h0}, 1,
                mk(64'h70, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h71, 1'b1, 1'b0, 1'b0)};
    tbl[4]  = '{64'h80, {16'h215A, 64'h0}, 2,
                mk(64'h80, 4'h2, 4'h1, 4'h5, 4'hA, 64'h0, 64'h82, 1'b1, 1'b0, 1'b0)};
    tbl[5]  = '{64'h90, 80'h5012_00000000000000FF, 10,
                mk(64'h90, 4'h5, 4'h0, 4'h1, 4'h2, 64'hFF, 64'h9A, 1'b1, 1'b0, 1'b0)};
    tbl[6]  = '{64'hA0, {16'hA06F, 64'h0}, 2,
                mk(64'hA0, 4'hA, 4'h0, 4'h6, 4'hF, 64'h0, 64'hA2, 1'b1, 1'b0, 1'b0)};
    tbl[7]  = '{64'd2044, {32'h80112233, 48'h0}, 4,
                mk(64'd2044, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1122330000000000, 64'd2053, 1'b1, 1'b1, 1'b0)};
    tbl[8]  = '{64'd2048, 80'h0, 0,
                mk(64'd2048, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd2048, 1'b1, 1'b1, 1'b0)};
    tbl[9]  = '{64'hB0, 80'h0, 1,
                mk(64'hB0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hB1, 1'b1, 1'b0, 1'b1)};
    tbl[10] = '{64'hC0, {8'hF5, 72'h0}, 1,
                mk(64'hC0, 4'hF, 4'h5, 4'hF, 4'hF, 64'h0, 64'hC1, 1'b0, 1'b0, 1'b0)};

    for (int i = 0; i < MEM; i++) mem[i] = 8'h00;
    wr(64'h0, 8'h30); wr(64'h1, 8'hF0); wr(64'h9, 8'h04); wr(64'hA, 8'h60); wr(64'hB, 8'h03);
    wr(64'h30, 8'h61); wr(64'h31, 8'h45);
    for (int i = 0; i < 16; i++) wr(64'h200 + 64'(i), 8'h10);
    for (int i = 0; i < 12; i++) begin
      wr(64'h100 + 64'(2*i), 8'h60 | 8'(i & 3));
      wr(64'h101 + 64'(2*i), {4'(i), ~4'(i)});
    end

    // Reset values, then straight-line program from address 0.
    out_ready = 1'b1;
    step(); step();
    chk("reset_vals", {imem_req, out_valid, imem_addr, cur()}, {2'b00, 64'h0, rst_e});
    sb.push_back(mk(64'h0, 4'h3, 4'h0, 4'hF, 4'h0, 64'h4, 64'hA, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(64'hA, 4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 64'hC, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(64'hC, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hD, 1'b1, 1'b0, 1'b1));
    rst_n = 1'b1;
    step();
    chk("first_req", {imem_req, imem_addr}, {1'b1, 64'h0});
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("first_valid_cycle", cyc, 5);
    wait_drain("a_drain", 100);
    check_stop("a_stop", 6);

    // Decode vectors, held under backpressure.
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < tbl[i].nb; k++) wr(tbl[i].pc + 64'(k), tbl[i].bytes[79-8*k -: 8]);
      redirect_to(tbl[i].pc);
      for (int c = 0; c < 30 && !out_valid; c++) step();
      chk($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("tbl%0d", i), cur(), tbl[i].e);
    end

    // Long backpressure: queue fills to 16 bytes, outputs hold, then drains in order.
    for (int i = 0; i < 12; i++)
      sb.push_back(mk(64'h100 + 64'(2*i), 4'h6, 4'(i & 3), 4'(i), ~4'(i), 64'h0,
                      64'h102 + 64'(2*i), 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(64'h118, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h119, 1'b1, 1'b0, 1'b1));
    redirect_to(64'h100);
    nreq = 0; have = 1'b0; bad = 1'b0; snap = '0;
    for (int c = 0; c < 20; c++) begin
      if (imem_req) nreq++;
      if (out_valid) begin
        if (!have) begin
          snap = cur();
          have = 1'b1;
        end else if (cur() !== snap) bad = 1'b1;
      end
      step();
    end
    chk("b_req_count", nreq, 4);
    chk("b_hold", {have, bad}, 2'b10);
    chk("b_req_idle", imem_req, 1'b0);
    out_ready = 1'b1;
    wait_drain("b_drain", 200);
    check_stop("b_stop", 4);

    // Redirect while a request is in flight: the stale beat must be dropped.
    out_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 64'h200;
    step();
    chk("c_req", {imem_req, imem_addr}, {1'b1, 64'h200});
    sb.push_back(mk(64'h30, 4'h6, 4'h1, 4'h4, 4'h5, 64'h0, 64'h32, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(64'h32, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h33, 1'b1, 1'b0, 1'b1));
    redirect_pc = 64'h30;
    step();
    redirect = 1'b0;
    out_ready = 1'b1;
    wait_drain("c_drain", 100);
    check_stop("c_stop", 4);

    // Halt at 0x14, stay stopped, then restart via redirect with two-byte latency.
    sb.push_back(mk(64'h14, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h15, 1'b1, 1'b0, 1'b1));
    redirect_to(64'h14);
    wait_drain("d_drain", 100);
    check_stop("d_stop", 8);
    out_ready = 1'b0;
    sb.push_back(mk(64'h30, 4'h6, 4'h1, 4'h4, 4'h5, 64'h0, 64'h32, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(64'h32, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h33, 1'b1, 1'b0, 1'b1));
    redirect_to(64'h30);
    chk("d_restart_req", imem_req, 1'b1);
    v1 = out_valid; step();
    v2 = out_valid; step();
    v3 = out_valid;
    chk("d_latency", {v1, v2, v3}, 3'b001);
    out_ready = 1'b1;
    wait_drain("d_restart_drain", 100);
    check_stop("d_restart_stop", 4);

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b0;
    redirect_to(64'h100);
    for (int c = 0; c < 20 && !out_valid; c++) step();
    chk("g_valid_before_reset", out_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("g_reset_vals", {imem_req, out_valid, imem_addr, cur()}, {2'b00, 64'h0, rst_e});
    step();
    rst_n = 1'b1;
    step();

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
